tick_irq_source: RTL and testbench
==================================

Name: tick_irq_source

Overview:
- APB-programmable interrupt source for the interrupt-handler environment. Sits directly downstream of the clock/reset generator: consumes its four slow divided clocks as tick inputs, clocked by pclk and reset by preset_n.
- Each channel counts rising edges of its tick input. After a programmable number of edges it raises a pending bit and a maskable interrupt request toward the interrupt handler.

Parameters:
- NCH, 4, number of tick channels (fixed at 4 by the register map).
- CW, 8, per-channel counter/compare width.

Ports:
- pclk  input  1  system clock; all state on rising edge.
- preset_n  input  1  synchronous active-low reset, sampled on pclk rising edge.
- psel  input  1  APB select.
- penable  input  1  APB access phase.
- pwrite  input  1  1 = write, 0 = read.
- paddr  input  8  byte address; [1:0] ignored.
- pwdata  input  32  write data.
- prdata  output  32  read data.
- pready  output  1  tied to 1 (zero wait states).
- pslverr  output  1  error response for unmapped address.
- tick_in  input  4  slow tick sources (divided clocks); treated as asynchronous.
- irq  output  4  per-channel interrupt request, registered.
- irq_any  output  1  OR of irq, registered.

Behaviour:
- Reset (preset_n=0 at an edge): CTRL, CMP, CNT, PEND, sync flops, irq and irq_any all go to 0 at that edge. Reset mid-count or mid-pending discards all state. An APB write in the same cycle as reset is ignored.
- Register map (paddr[7:2]):
  - 0x00 CTRL rw: [3:0] en, [7:4] ie.
  - 0x04 PEND: [3:0] pending, read, write-1-to-clear.
  - 0x08 CMP rw: [8i+7:8i] cmp[i].
  - 0x0C CNT ro: [8i+7:8i] cnt[i].
  - Unused bits read 0.
- APB access:
  - Write commits at the edge where psel&penable&pwrite.
  - prdata is combinational: selected register when psel&!pwrite, else 0.
  - pslverr = psel&penable when paddr[7:4]!=0. Such writes have no effect and such reads return 0.
  - Writes to CNT are ignored with no error.
- Tick synchronisation per channel: s1<=tick_in, s2<=s1, s3<=s2; rise = s2 & ~s3.
  - Latency: tick_in high before edge E0 → rise true during cycle after E1 → cnt/pend update at E2 → irq at E3.
- Counting, at an edge where rise[i] && en[i]:
  - If cnt[i]==cmp[i]: cnt[i]<=0 and pend[i]<=1.
  - Else: cnt[i]<=cnt[i]+1.
  - cmp=0 pends on every rise; cmp=255 pends every 256 rises. No overflow is possible since cnt never exceeds cmp.
- Edge cases:
  - en[i]=0: cnt[i] cleared and held at 0; rises ignored; pend[i] retained.
  - Any write to CMP clears all cnt to 0 at the same edge; a rise at that edge is discarded.
  - If cmp is written below the current cnt, it takes effect via that clear.
  - PEND W1C and a new set on the same edge: set wins, pend stays 1.
  - Writing 0 bits to PEND has no effect.
- Outputs: irq[i] <= pend[i]&ie[i]; irq_any <= |(pend&ie). Both are one cycle behind pend/ie.
- Clearing ie masks irq next cycle without touching pend.

Test Plan:
- Reset: preset_n low 5 cycles with tick_in toggling → irq=0, irq_any=0, all registers read 0, pslverr=0.
- Ch0 period: tick_in[0] period 20 (pclk 10), CMP=0x03, CTRL=0x11 → PEND[0] sets every 8 pclk. irq[0] rises 1 cycle after PEND[0]. CNT[7:0] reads cycle 0,1,2,3.
- W1C race: write PEND=0x1 on the same edge a ch0 compare hit occurs → PEND[0] stays 1. A later write with no hit clears it to 0 and irq[0] drops one cycle later.
- Masking/enable: pend[2] set, write CTRL with ie[2]=0 → irq[2]=0 while PEND[2]=1. en[2]=0 → CNT[23:16]=0 and no further pends.
- Error/CMP clear: read 0x20 → pslverr=1, prdata=0. Write CMP mid-count (cnt[1]=5) → CNT=0 next cycle.
- Reset mid-operation: assert preset_n with pend=0xF and irq=0xF → all 0 at the next edge. Counting restarts only after CTRL is reprogrammed.

Source files
------------

// File: rtl/tick_irq_source.sv
// tick_irq_source: APB-programmable interrupt source counting rising edges
// of four asynchronous slow ticks; raises pending bits and masked irqs.
//
// Ports:
//   pclk, preset_n      clock, synchronous active-low reset
//   psel/penable/pwrite APB control; paddr byte address, pwdata write data
//   prdata              combinational read data
//   pready              always 1 (no wait states)
//   pslverr             error on access to paddr[7:4] != 0
//   tick_in[3:0]        asynchronous tick sources
//   irq[3:0], irq_any   registered interrupt requests
module tick_irq_source #(
   parameter int NCH = 4,
   parameter int CW  = 8
) (
   input  logic              pclk,
   input  logic              preset_n,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [7:0]        paddr,
   input  logic [31:0]       pwdata,
   output logic [31:0]       prdata,
   output logic              pready,
   output logic              pslverr,
   input  logic [NCH-1:0]    tick_in,
   output logic [NCH-1:0]    irq,
   output logic              irq_any
);

   localparam logic [1:0] A_CTRL = 2'd0;
   localparam logic [1:0] A_PEND = 2'd1;
   localparam logic [1:0] A_CMP  = 2'd2;
   localparam logic [1:0] A_CNT  = 2'd3;

   logic [NCH-1:0] r_en;
   logic [NCH-1:0] r_ie;
   logic [NCH-1:0] r_pend;
   logic [CW-1:0]  r_cmp [NCH];
   logic [CW-1:0]  r_cnt [NCH];
   logic [NCH-1:0] r_s1;
   logic [NCH-1:0] r_s2;
   logic [NCH-1:0] r_s3;
   logic [NCH-1:0] r_irq;
   logic           r_irq_any;

   logic           w_err;
   logic           w_wr;
   logic           w_wr_ctrl;
   logic           w_wr_pend;
   logic           w_wr_cmp;
   logic [NCH-1:0] w_rise;
   logic [NCH-1:0] w_hit;
   logic [NCH-1:0] w_clr;
   logic [31:0]    w_cmp_flat;
   logic [31:0]    w_cnt_flat;
   logic           w_unused_addr;

   // Byte-lane bits of the address carry no meaning here.
   assign w_unused_addr = &{1'b0, paddr[1:0]};

   assign w_err     = (paddr[7:4] != 4'd0);
   assign w_wr      = psel & penable & pwrite & ~w_err;
   assign w_wr_ctrl = w_wr & (paddr[3:2] == A_CTRL);
   assign w_wr_pend = w_wr & (paddr[3:2] == A_PEND);
   assign w_wr_cmp  = w_wr & (paddr[3:2] == A_CMP);

   assign w_rise = r_s2 & ~r_s3;
   assign w_clr  = w_wr_pend ? pwdata[NCH-1:0] : '0;

   // A CMP write restarts every channel, so a rise on that edge is dropped.
   always_comb begin
      w_hit      = '0;
      w_cmp_flat = '0;
      w_cnt_flat = '0;
      for (int i = 0; i < NCH; i++) begin
         w_hit[i] = w_rise[i] & r_en[i] & ~w_wr_cmp
                  & (r_cnt[i] == r_cmp[i]);
         w_cmp_flat[i*CW +: CW] = r_cmp[i];
         w_cnt_flat[i*CW +: CW] = r_cnt[i];
      end
   end

   always_ff @(posedge pclk) begin
      if (!preset_n) begin
         r_en      <= '0;
         r_ie      <= '0;
         r_pend    <= '0;
         r_s1      <= '0;
         r_s2      <= '0;
         r_s3      <= '0;
         r_irq     <= '0;
         r_irq_any <= 1'b0;
         for (int i = 0; i < NCH; i++) begin
            r_cmp[i] <= '0;
            r_cnt[i] <= '0;
         end
      end else begin
         r_s1 <= tick_in;
         r_s2 <= r_s1;
         r_s3 <= r_s2;

         if (w_wr_ctrl) begin
            r_en <= pwdata[NCH-1:0];
            r_ie <= pwdata[2*NCH-1:NCH];
         end

         // New hits override a same-edge write-1-to-clear.
         r_pend <= (r_pend & ~w_clr) | w_hit;

         for (int i = 0; i < NCH; i++) begin
            if (w_wr_cmp)
               r_cmp[i] <= pwdata[i*CW +: CW];
            if (!r_en[i] || w_wr_cmp)
               r_cnt[i] <= '0;
            else if (w_rise[i])
               r_cnt[i] <= (r_cnt[i] == r_cmp[i]) ?
                           '0 : r_cnt[i] + CW'(1);
         end

         r_irq     <= r_pend & r_ie;
         r_irq_any <= |(r_pend & r_ie);
      end
   end

   always_comb begin
      prdata = '0;
      if (psel && !pwrite && !w_err) begin
         unique case (paddr[3:2])
            A_CTRL:  prdata = {{(32-2*NCH){1'b0}}, r_ie, r_en};
            A_PEND:  prdata = {{(32-NCH){1'b0}}, r_pend};
            A_CMP:   prdata = w_cmp_flat;
            A_CNT:   prdata = w_cnt_flat;
            default: prdata = '0;
         endcase
      end
   end

   assign pready  = 1'b1;
   assign pslverr = psel & penable & w_err;
   assign irq     = r_irq;
   assign irq_any = r_irq_any;

endmodule

// File: tb/tb_tick_irq_source.sv
// tb_tick_irq_source: directed self-checking bench for tick_irq_source.
// Ticks are single hand-timed pulses so every count is known exactly.
module tb_tick_irq_source;

   logic        pclk;
   logic        preset_n;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [7:0]  paddr;
   logic [31:0] pwdata;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;
   logic [3:0]  tick_in;
   logic [3:0]  irq;
   logic        irq_any;

   int n_chk;
   int n_fail;

   localparam logic [7:0] CTRL = 8'h00;
   localparam logic [7:0] PEND = 8'h04;
   localparam logic [7:0] CMP  = 8'h08;
   localparam logic [7:0] CNT  = 8'h0C;

   tick_irq_source dut (
      .pclk     (pclk),
      .preset_n (preset_n),
      .psel     (psel),
      .penable  (penable),
      .pwrite   (pwrite),
      .paddr    (paddr),
      .pwdata   (pwdata),
      .prdata   (prdata),
      .pready   (pready),
      .pslverr  (pslverr),
      .tick_in  (tick_in),
      .irq      (irq),
      .irq_any  (irq_any)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   // Called at a negedge; commit happens 1.5 cycles later, returns
   // at the negedge right after the commit edge.
   task automatic apb_wr(input logic [7:0] a, input logic [31:0] d);
      psel    = 1'b1;
      pwrite  = 1'b1;
      penable = 1'b0;
      paddr   = a;
      pwdata  = d;
      @(negedge pclk);
      penable = 1'b1;
      @(negedge pclk);
      psel    = 1'b0;
      penable = 1'b0;
      pwrite  = 1'b0;
   endtask

   task automatic apb_rd(input logic [7:0] a,
                         output logic [31:0] d,
                         output logic e);
      psel    = 1'b1;
      pwrite  = 1'b0;
      penable = 1'b0;
      paddr   = a;
      @(negedge pclk);
      penable = 1'b1;
      #1;
      d = prdata;
      e = pslverr;
      @(negedge pclk);
      psel    = 1'b0;
      penable = 1'b0;
   endtask

   task automatic rd_chk(input string tag,
                         input logic [7:0] a,
                         input logic [31:0] exp);
      logic [31:0] d;
      logic        e;
      apb_rd(a, d, e);
      chk(tag, d, exp);
   endtask

   // One rise per call: high 2 cycles, low 2 cycles. Counter update
   // lands 3 negedges after start, irq after 3.5, so both are settled
   // on return.
   task automatic pulse(input logic [3:0] m);
      tick_in = tick_in | m;
      repeat (2) @(negedge pclk);
      tick_in = tick_in & ~m;
      repeat (2) @(negedge pclk);
   endtask

   logic [31:0] rd;
   logic        er;

   initial begin
      n_chk    = 0;
      n_fail   = 0;
      preset_n = 1'b0;
      psel     = 1'b0;
      penable  = 1'b0;
      pwrite   = 1'b0;
      paddr    = '0;
      pwdata   = '0;
      tick_in  = '0;

      // Reset with ticks toggling.
      repeat (5) begin
         @(negedge pclk);
         tick_in = ~tick_in;
      end
      @(negedge pclk);
      chk("rst_irq", {28'd0, irq}, 32'h0);
      chk("rst_irq_any", {31'd0, irq_any}, 32'h0);
      tick_in  = '0;
      preset_n = 1'b1;
      repeat (4) @(negedge pclk);
      apb_rd(CTRL, rd, er);
      chk("rst_ctrl", rd, 32'h0);
      chk("rst_slverr", {31'd0, er}, 32'h0);
      rd_chk("rst_pend", PEND, 32'h0);
      rd_chk("rst_cmp", CMP, 32'h0);
      rd_chk("rst_cnt", CNT, 32'h0);
      chk("pready", {31'd0, pready}, 32'h1);

      // Ch0 period: cmp=3 pends on the 4th rise.
      apb_wr(CMP, 32'h0000_0003);
      apb_wr(CTRL, 32'h0000_0011);
      rd_chk("ctrl_rb", CTRL, 32'h11);
      pulse(4'h1);
      rd_chk("cnt_1", CNT, 32'h1);
      pulse(4'h1);
      rd_chk("cnt_2", CNT, 32'h2);
      pulse(4'h1);
      rd_chk("cnt_3", CNT, 32'h3);
      rd_chk("pend_pre", PEND, 32'h0);
      tick_in = 4'h1;
      repeat (2) @(negedge pclk);
      tick_in = 4'h0;
      @(negedge pclk);
      chk("irq_lag", {28'd0, irq}, 32'h0);
      @(negedge pclk);
      chk("irq0_set", {28'd0, irq}, 32'h1);
      chk("irq_any_set", {31'd0, irq_any}, 32'h1);
      rd_chk("pend_hit", PEND, 32'h1);
      rd_chk("cnt_wrap", CNT, 32'h0);

      // W1C on the same edge as a compare hit: set wins.
      pulse(4'h1);
      pulse(4'h1);
      pulse(4'h1);
      rd_chk("cnt_race", CNT, 32'h3);
      fork
         pulse(4'h1);
         begin
            @(negedge pclk);
            apb_wr(PEND, 32'h1);
         end
      join
      rd_chk("pend_race", PEND, 32'h1);
      rd_chk("cnt_race0", CNT, 32'h0);
      apb_wr(PEND, 32'h1);
      chk("irq_hold", {28'd0, irq}, 32'h1);
      @(negedge pclk);
      chk("irq_drop", {28'd0, irq}, 32'h0);
      rd_chk("pend_clr", PEND, 32'h0);

      // Masking and enable on channel 2 (cmp[2]=2).
      apb_wr(CMP, 32'h0002_0003);
      apb_wr(CTRL, 32'h0000_0055);
      pulse(4'h4);
      pulse(4'h4);
      rd_chk("cnt2_2", CNT, 32'h0002_0000);
      pulse(4'h4);
      chk("irq2_set", {28'd0, irq}, 32'h4);
      pulse(4'h4);
      rd_chk("cnt2_1", CNT, 32'h0001_0000);
      apb_wr(CTRL, 32'h0000_0015);
      @(negedge pclk);
      chk("irq2_mask", {28'd0, irq}, 32'h0);
      chk("irq_any_mask", {31'd0, irq_any}, 32'h0);
      rd_chk("pend2_kept", PEND, 32'h4);
      apb_wr(CTRL, 32'h0000_0011);
      rd_chk("cnt2_dis", CNT, 32'h0);
      rd_chk("pend2_dis", PEND, 32'h4);
      apb_wr(PEND, 32'h0000_0000);
      rd_chk("pend_w0", PEND, 32'h4);
      apb_wr(PEND, 32'h0000_0004);
      pulse(4'h4);
      pulse(4'h4);
      pulse(4'h4);
      rd_chk("pend2_none", PEND, 32'h0);
      rd_chk("cnt2_none", CNT, 32'h0);

      // Error response and CMP-write clear.
      apb_rd(8'h20, rd, er);
      chk("err_slverr", {31'd0, er}, 32'h1);
      chk("err_rdata", rd, 32'h0);
      apb_wr(8'h20, 32'h0000_00FF);
      rd_chk("err_nowr", CTRL, 32'h11);
      apb_wr(CMP, 32'h0000_0A03);
      apb_wr(CTRL, 32'h0000_0022);
      repeat (5) pulse(4'h2);
      apb_rd(CNT, rd, er);
      chk("cnt1_5", rd, 32'h0000_0500);
      chk("ok_slverr", {31'd0, er}, 32'h0);
      apb_wr(CNT, 32'hFFFF_FFFF);
      rd_chk("cnt_ro", CNT, 32'h0000_0500);
      apb_wr(CMP, 32'h0000_0A03);
      rd_chk("cnt_cmpclr", CNT, 32'h0);
      rd_chk("cmp_rb", CMP, 32'h0000_0A03);

      // Reset while everything is pending.
      apb_wr(CMP, 32'h0);
      apb_wr(CTRL, 32'h0000_00FF);
      pulse(4'hF);
      chk("irq_all", {28'd0, irq}, 32'hF);
      chk("irq_any_all", {31'd0, irq_any}, 32'h1);
      preset_n = 1'b0;
      @(negedge pclk);
      chk("mrst_irq", {28'd0, irq}, 32'h0);
      chk("mrst_irq_any", {31'd0, irq_any}, 32'h0);
      preset_n = 1'b1;
      rd_chk("mrst_ctrl", CTRL, 32'h0);
      rd_chk("mrst_pend", PEND, 32'h0);
      rd_chk("mrst_cmp", CMP, 32'h0);
      pulse(4'hF);
      rd_chk("mrst_idle", PEND, 32'h0);
      apb_wr(CTRL, 32'h0000_000F);
      pulse(4'h1);
      rd_chk("mrst_restart", PEND, 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
